// File: rtl/wav_recorder_if.sv
// -----------------------------------------------------------------------------
// wav_recorder_if -- control, audio and capture-RAM bundle for wav_recorder.
//
// Signals
//   rec_start  : single-cycle request to begin a capture
//   rec_stop   : single-cycle request to end a capture early
//   audio_in   : 16-bit unsigned audio sample
//   ram_a      : write address to the capture RAM write port
//   ram_d      : write data (8-bit converted sample)
//   ram_we     : write strobe, one cycle per stored sample
//   recording  : high while a capture is in progress (LED drive)
//   done       : single-cycle pulse at the end of a capture
//   length     : byte count of the last completed capture
//
// Modports
//   master : the controlling side (drives controls/audio, observes outputs)
//   slave  : the recorder itself
// -----------------------------------------------------------------------------
interface wav_recorder_if #(
    parameter int ADDR_W = 14
);
    logic              rec_start;
    logic              rec_stop;
    logic [15:0]       audio_in;
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_d;
    logic              ram_we;
    logic              recording;
    logic              done;
    logic [ADDR_W:0]   length;

    modport master (
        output rec_start, rec_stop, audio_in,
        input  ram_a, ram_d, ram_we, recording, done, length
    );

    modport slave (
        input  rec_start, rec_stop, audio_in,
        output ram_a, ram_d, ram_we, recording, done, length
    );
endinterface

// File: rtl/wav_recorder.sv
// -----------------------------------------------------------------------------
// wav_recorder -- captures 8-bit audio samples into a dual-port RAM.
//
// A prescaler divides clk down to the sample rate (period PRESCALE+1 clocks).
// On each sample tick the 16-bit unsigned input is reduced to 8 bits
// (bits 14:7, saturating to 8'hFF when bit 15 is set) and written to the
// next RAM address. A capture ends when the buffer is full or on rec_stop;
// the byte count is then published on length together with a done pulse.
//
// Ports
//   clk   : single clock, all state changes on its rising edge
//   reset : asynchronous active-high reset
//   bus   : wav_recorder_if.slave (controls, audio, RAM write port, status)
// -----------------------------------------------------------------------------
module wav_recorder #(
    parameter int PRESCALE = 2177,
    parameter int ADDR_W   = 14
) (
    input  logic           clk,
    input  logic           reset,
    wav_recorder_if.slave  bus
);

    localparam int PRES_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PRES_W-1:0] PRESCALE_C = PRES_W'(PRESCALE);
    // Last buffer address; addr_q carries one extra bit so it can also hold
    // the full-buffer write count 2^ADDR_W.
    localparam logic [ADDR_W:0]   LAST_ADDR  = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [PRES_W-1:0] presc_q;
    logic [ADDR_W:0]   addr_q;
    logic [ADDR_W-1:0] ram_a_q;
    logic [7:0]        ram_d_q;
    logic              ram_we_q;
    logic              recording_q;
    logic              done_q;
    logic [ADDR_W:0]   length_q;

    logic              tick_d;
    logic              last_d;
    logic [ADDR_W:0]   addr_d;

    // 16-bit unsigned sample to 8 bits, saturating on the top bit.
    function automatic logic [7:0] conv_sample(input logic [15:0] x);
        logic [7:0] r;
        if (x[15]) begin
            r = 8'hFF;
        end else begin
            r = x[14:7];
        end
        return r;
    endfunction

    assign tick_d = (presc_q == PRESCALE_C);
    assign last_d = (addr_q == LAST_ADDR);
    assign addr_d = addr_q + {{ADDR_W{1'b0}}, 1'b1};

    // Capture FSM with prescaler, address counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            presc_q     <= {PRES_W{1'b0}};
            addr_q      <= {(ADDR_W+1){1'b0}};
            ram_a_q     <= {ADDR_W{1'b0}};
            ram_d_q     <= 8'h00;
            ram_we_q    <= 1'b0;
            recording_q <= 1'b0;
            done_q      <= 1'b0;
            length_q    <= {(ADDR_W+1){1'b0}};
        end else begin
            // Strobes are one-cycle by default.
            ram_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // rec_stop is deliberately not looked at here.
                    if (bus.rec_start) begin
                        presc_q     <= {PRES_W{1'b0}};
                        addr_q      <= {(ADDR_W+1){1'b0}};
                        recording_q <= 1'b1;
                        state_q     <= REC;
                    end
                end
                REC: begin
                    if (tick_d) begin
                        presc_q  <= {PRES_W{1'b0}};
                        ram_we_q <= 1'b1;
                        ram_a_q  <= addr_q[ADDR_W-1:0];
                        ram_d_q  <= conv_sample(bus.audio_in);
                        addr_q   <= addr_d;
                    end else begin
                        presc_q  <= presc_q + {{(PRES_W-1){1'b0}}, 1'b1};
                    end
                    // A stop coinciding with a tick keeps that tick's write,
                    // so the count must include it.
                    if (bus.rec_stop || (tick_d && last_d)) begin
                        state_q     <= DONE;
                        recording_q <= 1'b0;
                        done_q      <= 1'b1;
                        length_q    <= tick_d ? addr_d : addr_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    recording_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_a     = ram_a_q;
    assign bus.ram_d     = ram_d_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.recording = recording_q;
    assign bus.done      = done_q;
    assign bus.length    = length_q;

endmodule

// File: tb/tb_wav_recorder.sv
// -----------------------------------------------------------------------------
// tb_wav_recorder -- directed self-checking bench for wav_recorder with
// PRESCALE=3 (write every 4 clocks) and ADDR_W=4 (16-byte buffer).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wav_recorder;

    localparam int PRESCALE = 3;
    localparam int ADDR_W   = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    wav_recorder_if #(.ADDR_W(ADDR_W)) bus ();

    wav_recorder #(
        .PRESCALE (PRESCALE),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One capture. The cycle where rec_start is driven is index 0; index k is
    // the k-th falling edge afterwards. Writes are expected at k = 5, 9, 13...
    // for the first exp_len ticks. stop_at > 0 drives rec_stop at that index,
    // restart_at > 0 drives a stray rec_start there.
    task automatic run_capture(input string name, input logic [15:0] audio,
                               input int stop_at, input bit start_with_stop,
                               input int restart_at, input int exp_len,
                               input logic [7:0] exp_d);
        int  k_done;
        bit  exp_we;
        k_done = (stop_at > 0 && stop_at < 64) ? stop_at + 1 : 65;
        bus.audio_in  = audio;
        bus.rec_start = 1'b1;
        bus.rec_stop  = start_with_stop;
        for (int k = 1; k <= k_done + 5; k++) begin
            @(negedge clk);
            exp_we = (k >= 5) && (((k - 5) % 4) == 0) && (((k - 5) / 4) < exp_len);
            check($sformatf("%s we k=%0d", name, k), {31'd0, bus.ram_we}, {31'd0, exp_we});
            if (exp_we) begin
                check($sformatf("%s addr k=%0d", name, k), {28'd0, bus.ram_a}, (k - 5) / 4);
                check($sformatf("%s data k=%0d", name, k), {24'd0, bus.ram_d}, {24'd0, exp_d});
            end
            check($sformatf("%s done k=%0d", name, k), {31'd0, bus.done}, {31'd0, (k == k_done)});
            check($sformatf("%s rec k=%0d", name, k), {31'd0, bus.recording}, {31'd0, (k < k_done)});
            bus.rec_start = (k == restart_at);
            bus.rec_stop  = (k == stop_at);
        end
        check({name, " length"}, {27'd0, bus.length}, exp_len);
    endtask

    initial begin
        clk           = 1'b0;
        reset         = 1'b1;
        n_checks      = 0;
        n_fail        = 0;
        bus.rec_start = 1'b0;
        bus.rec_stop  = 1'b0;
        bus.audio_in  = 16'h0000;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst ram_we", {31'd0, bus.ram_we}, 32'd0);
        check("rst ram_a", {28'd0, bus.ram_a}, 32'd0);
        check("rst ram_d", {24'd0, bus.ram_d}, 32'd0);
        check("rst recording", {31'd0, bus.recording}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst length", {27'd0, bus.length}, 32'd0);
        reset = 1'b0;

        // Full buffer with 16'h4080 -> 8'h81; stray rec_start at k=10 ignored.
        run_capture("full", 16'h4080, 0, 1'b0, 10, 16, 8'h81);
        // Stop two cycles after the 3rd write: 16'h1234 -> 8'h24.
        run_capture("early", 16'h1234, 15, 1'b0, 0, 3, 8'h24);
        // Stop on the first tick, saturating sample.
        run_capture("sat", 16'h9000, 4, 1'b0, 0, 1, 8'hFF);
        // rec_start together with rec_stop in IDLE still starts a capture.
        run_capture("both", 16'h0080, 0, 1'b1, 0, 16, 8'h01);

        // rec_stop alone in IDLE does nothing.
        bus.rec_stop = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.rec_stop = 1'b0;
            check($sformatf("idle stop rec k=%0d", k), {31'd0, bus.recording}, 32'd0);
            check($sformatf("idle stop done k=%0d", k), {31'd0, bus.done}, 32'd0);
            check($sformatf("idle stop we k=%0d", k), {31'd0, bus.ram_we}, 32'd0);
        end
        check("idle stop length", {27'd0, bus.length}, 32'd16);

        // Asynchronous reset mid-capture, applied between clock edges.
        bus.audio_in  = 16'h4080;
        bus.rec_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.rec_start = 1'b0;
        end
        check("pre-reset recording", {31'd0, bus.recording}, 32'd1);
        check("pre-reset ram_a", {28'd0, bus.ram_a}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async ram_we", {31'd0, bus.ram_we}, 32'd0);
        check("async ram_a", {28'd0, bus.ram_a}, 32'd0);
        check("async ram_d", {24'd0, bus.ram_d}, 32'd0);
        check("async recording", {31'd0, bus.recording}, 32'd0);
        check("async done", {31'd0, bus.done}, 32'd0);
        check("async length", {27'd0, bus.length}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("post-reset we k=%0d", k), {31'd0, bus.ram_we}, 32'd0);
            check($sformatf("post-reset done k=%0d", k), {31'd0, bus.done}, 32'd0);
            check($sformatf("post-reset rec k=%0d", k), {31'd0, bus.recording}, 32'd0);
        end
        // New capture restarts at address 0.
        run_capture("restart", 16'h4080, 4, 1'b0, 0, 1, 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
